memory_port_arbiter: RTL and testbench

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant, and a wait timer aborts hung accesses.
module memory_port_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        MEM_BUSY
    } state_e;

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    state_e             state_q, state_d;
    logic [2:0]         starve_cnt_q, starve_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               ram_req_q, ram_req_d;
    logic               ram_we_q, ram_we_d;
    logic [31:0]        ram_addr_q, ram_addr_d;
    logic [31:0]        ram_wdata_q, ram_wdata_d;
    logic               if_done_q, if_done_d;
    logic               mem_done_q, mem_done_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic               bus_err_q, bus_err_d;

    logic if_elig, mem_elig, done_bubble;
    logic grant_if, grant_mem;
    logic finish, timed_out;

    always_comb begin
        if_elig     = if_req & ~if_done_q;
        mem_elig    = mem_req & ~mem_done_q;
        // A done cycle is a bubble so a requester re-raising after its done still competes.
        done_bubble = if_done_q | mem_done_q;

        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state_q == IDLE && !done_bubble) begin
            if (mem_elig && !(if_elig && starve_cnt_q == STARVE_MAX)) begin
                grant_mem = 1'b1;
            end else if (if_elig) begin
                grant_if = 1'b1;
            end
        end

        timed_out = (state_q != IDLE) && !ram_ack && (wait_cnt_q == WAIT_LAST);
        finish    = (state_q != IDLE) && (ram_ack || timed_out);
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        ram_req_d    = ram_req_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        bus_err_d    = bus_err_q;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d     = MEM_BUSY;
                    wait_cnt_d  = '0;
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                end else if (grant_if) begin
                    state_d     = IF_BUSY;
                    wait_cnt_d  = '0;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                end
            end
            IF_BUSY: begin
                if (finish) begin
                    state_d    = IDLE;
                    ram_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = ram_ack ? ram_rdata : '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            MEM_BUSY: begin
                if (finish) begin
                    state_d    = IDLE;
                    ram_req_d  = 1'b0;
                    mem_done_d = 1'b1;
                    if (!ram_ack) begin
                        mem_rdata_d = '0;
                    end else if (!ram_we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
            end
        endcase

        if (timed_out) begin
            bus_err_d = 1'b1;
        end

        // Starvation only accrues while a fetch is actually waiting.
        if (!if_req || grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_mem && starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            if_done_q    <= if_done_d;
            mem_done_q   <= mem_done_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign bus_err   = bus_err_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: cycle vector table plus starvation, timeout and reset sequences.
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_req, mem_we, ram_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
    logic        if_done, mem_done, stall_if, stall_mem, ram_req, ram_we, bus_err;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .TIMEOUT      (16),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ack   (ram_ack),
        .ram_rdata (ram_rdata),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic        rst_n, if_req;
        logic [31:0] if_addr;
        logic        mem_req, mem_we;
        logic [31:0] mem_addr, mem_wdata;
        logic        ram_ack;
        logic [31:0] ram_rdata;
        logic        e_ram_req, e_ram_we;
        logic [31:0] e_ram_addr, e_ram_wdata;
        logic        e_if_done;
        logic [31:0] e_if_rdata;
        logic        e_mem_done;
        logic [31:0] e_mem_rdata;
        logic        e_stall_if, e_stall_mem, e_bus_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_ack = 1'b0; ram_rdata = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int data_g, cyc, n;
        logic fetch_seen, prev_req, fetch_we;

        // Inputs (rst,ifr,ifa,mr,mwe,ma,mwd,ack,rd) | expected after the edge
        // (ram_req,ram_we,ram_addr,ram_wdata,if_done,if_rdata,mem_done,mem_rdata,stall_if,stall_mem,bus_err)
        vecs[0]  = '{0,0,32'h0, 0,0,32'h0,  32'h0,        0,32'h0,        0,0,32'h0,  32'h0,        0,32'h0,        0,32'h0,        0,0,0};
        vecs[1]  = '{0,0,32'h0, 0,0,32'h0,  32'h0,        0,32'h0,        0,0,32'h0,  32'h0,        0,32'h0,        0,32'h0,        0,0,0};
        vecs[2]  = '{1,0,32'h0, 0,0,32'h0,  32'h0,        1,32'hDEADBEEF, 0,0,32'h0,  32'h0,        0,32'h0,        0,32'h0,        0,0,0};
        vecs[3]  = '{1,1,32'h40,0,0,32'h0,  32'h0,        0,32'h0,        1,0,32'h40, 32'h0,        0,32'h0,        0,32'h0,        1,0,0};
        vecs[4]  = '{1,1,32'h40,0,0,32'h0,  32'h0,        0,32'h0,        1,0,32'h40, 32'h0,        0,32'h0,        0,32'h0,        1,0,0};
        vecs[5]  = '{1,1,32'h40,0,0,32'h0,  32'h0,        0,32'h0,        1,0,32'h40, 32'h0,        0,32'h0,        0,32'h0,        1,0,0};
        vecs[6]  = '{1,1,32'h40,0,0,32'h0,  32'h0,        1,32'h8C090004, 0,0,32'h40, 32'h0,        1,32'h8C090004, 0,32'h0,        0,0,0};
        vecs[7]  = '{1,0,32'h40,0,0,32'h0,  32'h0,        0,32'h0,        0,0,32'h40, 32'h0,        0,32'h8C090004, 0,32'h0,        0,0,0};
        vecs[8]  = '{1,1,32'h44,1,1,32'h100,32'hA5A5A5A5, 0,32'h0,        1,1,32'h100,32'hA5A5A5A5, 0,32'h8C090004, 0,32'h0,        1,1,0};
        vecs[9]  = '{1,1,32'h44,1,1,32'h100,32'hA5A5A5A5, 1,32'h12345678, 0,1,32'h100,32'hA5A5A5A5, 0,32'h8C090004, 1,32'h0,        1,0,0};
        vecs[10] = '{1,1,32'h44,0,1,32'h100,32'hA5A5A5A5, 0,32'h0,        0,1,32'h100,32'hA5A5A5A5, 0,32'h8C090004, 0,32'h0,        1,0,0};
        vecs[11] = '{1,1,32'h44,0,1,32'h100,32'hA5A5A5A5, 0,32'h0,        1,0,32'h44, 32'h0,        0,32'h8C090004, 0,32'h0,        1,0,0};
        vecs[12] = '{1,1,32'h44,0,1,32'h100,32'hA5A5A5A5, 1,32'h0BADF00D, 0,0,32'h44, 32'h0,        1,32'h0BADF00D, 0,32'h0,        0,0,0};
        vecs[13] = '{1,0,32'h44,0,1,32'h100,32'hA5A5A5A5, 0,32'h0,        0,0,32'h44, 32'h0,        0,32'h0BADF00D, 0,32'h0,        0,0,0};
        vecs[14] = '{1,0,32'h44,1,0,32'h200,32'hA5A5A5A5, 0,32'h0,        1,0,32'h200,32'hA5A5A5A5, 0,32'h0BADF00D, 0,32'h0,        0,1,0};
        vecs[15] = '{1,0,32'h44,1,1,32'h300,32'h5A5A5A5A, 0,32'h0,        1,0,32'h200,32'hA5A5A5A5, 0,32'h0BADF00D, 0,32'h0,        0,1,0};
        vecs[16] = '{1,0,32'h44,1,1,32'h300,32'h5A5A5A5A, 1,32'hCAFEBABE, 0,0,32'h200,32'hA5A5A5A5, 0,32'h0BADF00D, 1,32'hCAFEBABE, 0,0,0};
        vecs[17] = '{1,0,32'h44,0,0,32'h0,  32'h0,        0,32'h0,        0,0,32'h200,32'hA5A5A5A5, 0,32'h0BADF00D, 0,32'hCAFEBABE, 0,0,0};

        for (int i = 0; i < NV; i++) begin
            rst_n = vecs[i].rst_n; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            mem_req = vecs[i].mem_req; mem_we = vecs[i].mem_we; mem_addr = vecs[i].mem_addr;
            mem_wdata = vecs[i].mem_wdata; ram_ack = vecs[i].ram_ack; ram_rdata = vecs[i].ram_rdata;
            step();
            check($sformatf("v%0d.ram_req", i),   32'(ram_req),   32'(vecs[i].e_ram_req));
            check($sformatf("v%0d.ram_we", i),    32'(ram_we),    32'(vecs[i].e_ram_we));
            check($sformatf("v%0d.ram_addr", i),  ram_addr,       vecs[i].e_ram_addr);
            check($sformatf("v%0d.ram_wdata", i), ram_wdata,      vecs[i].e_ram_wdata);
            check($sformatf("v%0d.if_done", i),   32'(if_done),   32'(vecs[i].e_if_done));
            check($sformatf("v%0d.if_rdata", i),  if_rdata,       vecs[i].e_if_rdata);
            check($sformatf("v%0d.mem_done", i),  32'(mem_done),  32'(vecs[i].e_mem_done));
            check($sformatf("v%0d.mem_rdata", i), mem_rdata,      vecs[i].e_mem_rdata);
            check($sformatf("v%0d.stall_if", i),  32'(stall_if),  32'(vecs[i].e_stall_if));
            check($sformatf("v%0d.stall_mem", i), 32'(stall_mem), 32'(vecs[i].e_stall_mem));
            check($sformatf("v%0d.bus_err", i),   32'(bus_err),   32'(vecs[i].e_bus_err));
        end

        // Starvation: fetch held, data requester always busy; memory acks every request next cycle.
        do_reset();
        if_req = 1'b1; if_addr = 32'h80; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
        data_g = 0; cyc = 0; fetch_seen = 1'b0; prev_req = 1'b0; fetch_we = 1'b1;
        while (!fetch_seen && cyc < 200) begin
            step();
            cyc++;
            if (ram_req && !prev_req) begin
                if (ram_addr == 32'h80) begin
                    fetch_seen = 1'b1;
                    fetch_we = ram_we;
                end else begin
                    data_g++;
                end
            end
            prev_req = ram_req;
            ram_ack = ram_req;
            ram_rdata = 32'h1000 + 32'(cyc);
        end
        check("starve.fetch_granted", 32'(fetch_seen), 32'd1);
        check("starve.data_grants", 32'(data_g), 32'd4);
        check("starve.fetch_we", 32'(fetch_we), 32'd0);
        check("starve.cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
        ram_rdata = 32'h600DF00D;
        step();
        check("starve.if_done", 32'(if_done), 32'd1);
        check("starve.if_rdata", if_rdata, 32'h600DF00D);
        if_req = 1'b0; mem_req = 1'b0; ram_ack = 1'b0;
        step();
        step();

        // Timeout: a good read first so the zero load on timeout is observable.
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
        step();
        ram_ack = 1'b1; ram_rdata = 32'h11112222;
        step();
        check("to.pre_done", 32'(mem_done), 32'd1);
        check("to.pre_rdata", mem_rdata, 32'h11112222);
        mem_req = 1'b0; ram_ack = 1'b0;
        step();
        mem_req = 1'b1; mem_addr = 32'h504;
        step();
        check("to.grant", 32'(ram_req), 32'd1);
        n = 0;
        while (ram_req && n < 40) begin
            n++;
            step();
        end
        check("to.busy_cycles", 32'(n), 32'd16);
        check("to.ram_req", 32'(ram_req), 32'd0);
        check("to.mem_done", 32'(mem_done), 32'd1);
        check("to.mem_rdata", mem_rdata, 32'h0);
        check("to.bus_err", 32'(bus_err), 32'd1);
        mem_req = 1'b0;
        step();
        ram_ack = 1'b1; ram_rdata = 32'h99999999;
        step();
        ram_ack = 1'b0;
        step();
        check("to.late_ack_no_done", 32'(mem_done), 32'd0);
        check("to.late_ack_rdata", mem_rdata, 32'h0);
        check("to.bus_err_sticky", 32'(bus_err), 32'd1);
        do_reset();
        step();
        check("to.bus_err_reset", 32'(bus_err), 32'd0);

        // Reset during a fetch, followed by a stray ack.
        do_reset();
        if_req = 1'b1; if_addr = 32'h60;
        step();
        check("rst.grant", 32'(ram_req), 32'd1);
        check("rst.addr", ram_addr, 32'h60);
        step();
        rst_n = 1'b0;
        step();
        check("rst.ram_req", 32'(ram_req), 32'd0);
        check("rst.ram_addr", ram_addr, 32'h0);
        rst_n = 1'b1; if_req = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h77777777;
        step();
        check("rst.no_if_done", 32'(if_done), 32'd0);
        check("rst.if_rdata", if_rdata, 32'h0);
        check("rst.idle_req", 32'(ram_req), 32'd0);
        ram_ack = 1'b0;
        step();
        check("rst.still_no_done", 32'(if_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
